j_chunk_streamer: RTL and testbench

Memory-side feeder for the MatMul energy engine: on a start pulse it reads the J matrix from on-chip SRAM one MEM_BANDWIDTH-bit word at a time. It presents each word as one J chunk (VECTOR_SIZE rows x J_COLS_PER_READ columns) on a valid/ready stream. Backpressure uses a credit scheme plus a small buffer, so no read data is ever dropped. An abort input supports MatMul early stop.

---
 rtl/matmul_pkg.sv | 31 +++
 rtl/j_chunk_fifo.sv | 73 +++++++
 rtl/j_chunk_streamer.sv | 118 +++++++++++
 tb/tb_j_chunk_streamer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared MatMul definitions: J-matrix geometry, chunk-stream state encoding
// and the mapping of J elements onto a chunk word.
package matmul_pkg;

    localparam int MEM_BANDWIDTH   = 4096;
    localparam int VECTOR_SIZE     = 256;
    localparam int J_ELEMENT_WIDTH = 4;

    localparam int J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH);
    localparam int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ;
    localparam int CHUNK_IDX_WIDTH = $clog2(NUM_J_CHUNKS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } stream_state_e;

    typedef struct packed {
        logic [MEM_BANDWIDTH-1:0]   data;
        logic [CHUNK_IDX_WIDTH-1:0] idx;
        logic                       last;
    } chunk_entry_t;

    // Bit offset of element [row][col] inside one chunk word.
    function automatic int j_bit_offset(input int row, input int col);
        return (col * VECTOR_SIZE + row) * J_ELEMENT_WIDTH;
    endfunction

endpackage

// File: rtl/j_chunk_fifo.sv
// Small synchronous chunk buffer (data, index, last flag) with a flush input;
// the head entry reads as zero while the buffer is empty.
module j_chunk_fifo
    import matmul_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  wr_en,
    input  logic [MEM_BANDWIDTH-1:0]              wr_data,
    input  logic [CHUNK_IDX_WIDTH-1:0]            wr_idx,
    input  logic                                  wr_last,
    input  logic                                  rd_en,
    output logic                                  rd_valid,
    output logic [MEM_BANDWIDTH-1:0]              rd_data,
    output logic [CHUNK_IDX_WIDTH-1:0]            rd_idx,
    output logic                                  rd_last,
    output logic [$clog2(FIFO_DEPTH + 1)-1:0]     count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    chunk_entry_t     mem [FIFO_DEPTH];
    chunk_entry_t     head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             empty, full, pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = rd_en && !empty;
    assign head     = mem[rd_ptr];
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : head.data;
    assign rd_idx   = empty ? '0 : head.idx;
    assign rd_last  = !empty && head.last;

    // NOTE: storage has no reset; entries are only observable after a write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{data: wr_data, idx: wr_idx, last: wr_last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (pop)   rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(wr_en && full)) else $error("j_chunk_fifo: write into full buffer");
        end
    end

endmodule

// File: rtl/j_chunk_streamer.sv
// Reads the J matrix one SRAM word per chunk and streams it on valid/ready,
// using read credits so that returning SRAM data always has a buffer slot.
module j_chunk_streamer
    import matmul_pkg::*;
#(
    parameter int MEM_RD_LATENCY = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    output logic                       mem_rd_en,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [MEM_BANDWIDTH-1:0]   mem_rdata,
    output logic                       chunk_valid,
    input  logic                       chunk_ready,
    output logic [MEM_BANDWIDTH-1:0]   chunk_data,
    output logic [CHUNK_IDX_WIDTH-1:0] chunk_idx,
    output logic                       chunk_last,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CHUNK_IDX_WIDTH-1:0] LAST_IDX = CHUNK_IDX_WIDTH'(NUM_J_CHUNKS - 1);

    stream_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]      base_q;
    logic [CHUNK_IDX_WIDTH-1:0] rd_cnt, wr_idx;
    logic [MEM_RD_LATENCY-1:0]  rd_pipe;
    logic [CNT_W-1:0]           inflight, fifo_count;
    logic                       aborting, abort_now, credit_ok;
    logic                       rd_fire, capture, fifo_wr, handshake;

    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign abort_now = abort && busy;
    // A slot is reserved for every read still in the SRAM pipeline.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign rd_fire   = (state_q == ISSUE) && !abort && credit_ok;
    assign mem_rd_en = rd_fire;
    assign mem_addr  = base_q + ADDR_WIDTH'(rd_cnt);
    assign capture   = rd_pipe[MEM_RD_LATENCY-1];
    assign fifo_wr   = capture && !aborting && !abort_now;
    assign handshake = chunk_valid && chunk_ready;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: if (abort || (rd_fire && rd_cnt == LAST_IDX)) state_d = DRAIN;
            DRAIN: begin
                if (aborting) begin
                    if (inflight == '0) state_d = DONE;
                end else if (!abort && handshake && chunk_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            rd_cnt   <= '0;
            wr_idx   <= '0;
            rd_pipe  <= '0;
            inflight <= '0;
            aborting <= 1'b0;
        end else begin
            rd_pipe[0] <= rd_fire;
            for (int i = 1; i < MEM_RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
            inflight <= inflight + CNT_W'(rd_fire) - CNT_W'(capture);
            if (state_q == IDLE && start) begin
                base_q   <= base_addr;
                rd_cnt   <= '0;
                wr_idx   <= '0;
                aborting <= 1'b0;
            end else begin
                if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
                if (fifo_wr) wr_idx <= wr_idx + 1'b1;
                if (abort_now)              aborting <= 1'b1;
                else if (state_q == DONE)   aborting <= 1'b0;
            end
        end
    end

    j_chunk_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (abort_now),
        .wr_en    (fifo_wr),
        .wr_data  (mem_rdata),
        .wr_idx   (wr_idx),
        .wr_last  (wr_idx == LAST_IDX),
        .rd_en    (chunk_ready),
        .rd_valid (chunk_valid),
        .rd_data  (chunk_data),
        .rd_idx   (chunk_idx),
        .rd_last  (chunk_last),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_j_chunk_streamer.sv
// Scoreboard bench for j_chunk_streamer: expected chunks and read addresses are
// queued when a run is started and popped by a negedge monitor.
module tb_j_chunk_streamer;
    import matmul_pkg::*;

    localparam int L     = 1;
    localparam int DEPTH = 4;
    localparam int AW    = 16;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic                       abort = 1'b0;
    logic                       chunk_ready = 1'b1;
    logic [AW-1:0]              base_addr = '0;
    logic                       mem_rd_en;
    logic [AW-1:0]              mem_addr;
    logic [MEM_BANDWIDTH-1:0]   mem_rdata;
    logic                       chunk_valid;
    logic [MEM_BANDWIDTH-1:0]   chunk_data;
    logic [CHUNK_IDX_WIDTH-1:0] chunk_idx;
    logic                       chunk_last;
    logic                       busy;
    logic                       done;

    j_chunk_streamer #(
        .MEM_RD_LATENCY(L),
        .FIFO_DEPTH    (DEPTH),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_data  (chunk_data),
        .chunk_idx   (chunk_idx),
        .chunk_last  (chunk_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MEM_BANDWIDTH-1:0] data;
        int                       idx;
        logic                     last;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     data_mode = 0;
    int     ready_mode = 0;
    int     hs_count, last_hs_cyc, first_valid_cyc, first_rd_cyc, occ;
    int     run_start_cyc, run_done_cyc;
    bit     monitor_on = 0, track_occ = 0, post_abort = 0, stall_prev = 0;
    longint energy_ones, energy_alt;

    logic [MEM_BANDWIDTH-1:0]   prev_data;
    logic [CHUNK_IDX_WIDTH-1:0] prev_idx;
    logic                       prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [MEM_BANDWIDTH-1:0] fill(input logic [3:0] v);
        logic [MEM_BANDWIDTH-1:0] w;
        for (int i = 0; i < MEM_BANDWIDTH / 4; i++) w[i*4 +: 4] = v;
        return w;
    endfunction

    function automatic logic [MEM_BANDWIDTH-1:0] sram_word(input logic [AW-1:0] a);
        return fill(data_mode == 1 ? 4'hF : a[3:0]);
    endfunction

    function automatic int sgn(input int i);
        return (i % 2 == 0) ? 1 : -1;
    endfunction

    // SRAM model: data for the address presented with mem_rd_en appears L cycles later.
    logic [MEM_BANDWIDTH-1:0] sram_pipe [L];
    always @(posedge clk) begin
        sram_pipe[0] <= sram_word(mem_addr);
        for (int i = 1; i < L; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign mem_rdata = sram_pipe[L-1];

    initial forever begin
        @(posedge clk);
        #1;
        chunk_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input longint actual);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s actual=%0d", name, actual);
        end
    endtask

    task automatic check_data(input string name, input logic [MEM_BANDWIDTH-1:0] got,
                              input logic [MEM_BANDWIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got[63:0]=%h want[63:0]=%h", name, got[63:0], want[63:0]);
        end
    endtask

    // Monitor: pops expectations whenever the DUT issues a read or completes a handshake.
    always @(negedge clk) begin
        if (monitor_on) begin
            if (post_abort) begin
                check("abort_rd_en", mem_rd_en, 0);
                check("abort_valid", chunk_valid, 0);
                stall_prev = 0;
            end
            if (stall_prev) begin
                check("stall_idx", chunk_idx, prev_idx);
                check("stall_last", chunk_last, prev_last);
                check_data("stall_data", chunk_data, prev_data);
            end
            if (mem_rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (track_occ) check_true("credit_occupancy", occ < DEPTH, occ);
                if (addr_q.size() == 0) check_true("unexpected_read", 0, mem_addr);
                else check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (chunk_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (chunk_valid && chunk_ready) begin
                if (exp_q.size() == 0) begin
                    check_true("unexpected_chunk", 0, chunk_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("chunk_idx", chunk_idx, e.idx);
                    check("chunk_last", chunk_last, e.last);
                    check_data("chunk_data", chunk_data, e.data);
                end
                if (data_mode == 1) begin
                    for (int r = 0; r < VECTOR_SIZE; r++) begin
                        for (int c = 0; c < J_COLS_PER_READ; c++) begin
                            int v;
                            int col;
                            v   = int'(chunk_data[j_bit_offset(r, c) +: 4]);
                            col = int'(chunk_idx) * J_COLS_PER_READ + c;
                            energy_ones += longint'(v);
                            energy_alt  += longint'(v * sgn(r) * sgn(col));
                        end
                    end
                end
                hs_count++;
                last_hs_cyc = cyc;
                occ--;
            end
            if (mem_rd_en) occ++;
            stall_prev = chunk_valid && !chunk_ready && !post_abort;
            prev_data  = chunk_data;
            prev_idx   = chunk_idx;
            prev_last  = chunk_last;
        end
    end

    task automatic run(input string tag, input logic [AW-1:0] base, input int restart_at,
                       input int abort_at, input bit abort_with_start);
        logic [AW-1:0] a;
        exp_t          e;
        bit            got_done, restarted, aborted;
        int            abort_cyc, n;
        got_done  = 0;
        restarted = 0;
        aborted   = 0;
        abort_cyc = 0;
        for (int k = 0; k < NUM_J_CHUNKS; k++) begin
            a      = base + AW'(k);
            e.data = sram_word(a);
            e.idx  = k;
            e.last = (k == NUM_J_CHUNKS - 1);
            addr_q.push_back(a);
            exp_q.push_back(e);
        end
        hs_count        = 0;
        occ             = 0;
        first_valid_cyc = -1;
        first_rd_cyc    = -1;
        track_occ       = 1;
        post_abort      = 0;
        @(posedge clk);
        #1;
        base_addr     = base;
        start         = 1'b1;
        abort         = abort_with_start;
        run_start_cyc = cyc;
        for (n = 0; n < 2000 && !got_done; n++) begin
            @(posedge clk);
            #1;
            start     = 1'b0;
            abort     = 1'b0;
            base_addr = 16'hDEAD;
            if (restart_at >= 0 && hs_count >= restart_at && !restarted) begin
                start     = 1'b1;
                base_addr = 16'h0500;
                restarted = 1;
            end
            if (abort_at >= 0 && hs_count >= abort_at && !aborted) begin
                abort     = 1'b1;
                aborted   = 1;
                abort_cyc = cyc;
            end
            if (aborted && cyc == abort_cyc + 1) begin
                exp_q.delete();
                addr_q.delete();
                post_abort = 1;
                track_occ  = 0;
            end
            @(negedge clk);
            if (done) begin
                got_done     = 1;
                run_done_cyc = cyc;
            end
        end
        post_abort = 0;
        if (!got_done) begin
            check_true({tag, "_done_timeout"}, 0, n);
        end else if (abort_at < 0) begin
            check({tag, "_handshakes"}, hs_count, NUM_J_CHUNKS);
            check({tag, "_done_after_last"}, run_done_cyc, last_hs_cyc + 1);
            check({tag, "_chunks_left"}, exp_q.size(), 0);
            check({tag, "_reads_left"}, addr_q.size(), 0);
        end else begin
            check_true({tag, "_abort_inflight_seen"}, abort_cyc > 0, abort_cyc);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", chunk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_idx", chunk_idx, 0);
        check("rst_last", chunk_last, 0);
        check_true("rst_data_zero", chunk_data == '0, chunk_data[63:0]);
        @(posedge clk);
        #1;
        rst = 1'b0;
        monitor_on = 1;

        // Abort while idle has no effect.
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 0);

        run("stream", 16'h0100, -1, -1, 0);
        check("first_read_latency", first_rd_cyc - run_start_cyc, 1);
        check("first_valid_latency", first_valid_cyc - run_start_cyc, 1 + L + 1);
        check("total_cycles", run_done_cyc - run_start_cyc + 1, NUM_J_CHUNKS + L + 3);

        ready_mode = 1;
        run("backpressure", 16'h0300, -1, -1, 0);
        ready_mode = 0;

        run("wrap", 16'hFFE0, -1, -1, 0);
        run("restart_ignored", 16'h0100, 20, -1, 0);
        run("abort", 16'h0200, -1, 11, 0);

        data_mode   = 1;
        energy_ones = 0;
        energy_alt  = 0;
        run("energy", 16'h0400, -1, -1, 1);
        check("energy_all_ones", energy_ones, 64'd983040);
        check("energy_alternating", energy_alt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
